// File: rtl/bcd_banner_tx_pkg.sv
// Shared constants for the banner transmit path: ASCII codes used when
// rendering BCD digits and the FSM state encodings. The ASCII constants are
// also used by signal_decoder.
package bcd_banner_tx_pkg;

   // ASCII codes
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   // FSM state encodings
   localparam int unsigned STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_SEND    = 3'd1;
   localparam logic [STATE_W-1:0] ST_TERM_CR = 3'd2;
   localparam logic [STATE_W-1:0] ST_TERM_LF = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

   // Render one BCD nibble as ASCII; values above 9 become bad_char.
   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble,
                                               input logic [7:0] bad_char);
      if (nibble > 4'd9) begin
         return bad_char;
      end
      return ASCII_ZERO + {4'b0000, nibble};
   endfunction

endpackage

// File: rtl/bcd_banner_tx_bcd2ascii.sv
// Combinational BCD nibble to ASCII character converter.
module bcd2ascii
   import bcd_banner_tx_pkg::*;
#(
   parameter logic [7:0] BAD_CHAR = ASCII_QMARK
) (
   input  logic [3:0] bcd,
   output logic [7:0] ascii
);

   // Digits 0-9 map to '0'-'9'; anything else to BAD_CHAR
   always_comb begin
      ascii = bcd_to_ascii(bcd, BAD_CHAR);
   end

endmodule

// File: rtl/bcd_banner_tx.sv
// Banner transmitter: snapshots the displayed BCD digit set on start and
// writes it, most significant digit first, as ASCII into the UART TX FIFO.
// Optional macro BCD_BANNER_TX_CRLF_EN appends CR LF to each frame.
module bcd_banner_tx
   import bcd_banner_tx_pkg::*;
#(
   parameter int unsigned DIGITS   = 6,
   parameter logic [7:0]  BAD_CHAR = 8'h3F
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic                  tx_full,
   output logic [7:0]            data_out,
   output logic                  wr_data,
   output logic                  busy,
   output logic                  done_tick
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

   logic [STATE_W-1:0]   state_q, state_d;
   logic [4*DIGITS-1:0]  snap_q, snap_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [7:0]           last_q, last_d;

   logic [3:0]           digit;
   logic [7:0]           digit_char;
   logic                 wr;
   logic [7:0]           char;

   // Select the snapshot digit addressed by the current index
   always_comb begin
      digit = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            digit = snap_q[4*k +: 4];
         end
      end
   end

   bcd2ascii #(
      .BAD_CHAR (BAD_CHAR)
   ) u_bcd2ascii (
      .bcd   (digit),
      .ascii (digit_char)
   );

   // Next-state, snapshot, index and write-strobe logic
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      last_d  = last_q;
      wr      = 1'b0;
      char    = last_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               snap_d  = data_in;
               idx_d   = IDX_TOP;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_full) begin
               wr     = 1'b1;
               char   = digit_char;
               last_d = digit_char;
               if (idx_q == '0) begin
`ifdef BCD_BANNER_TX_CRLF_EN
                  state_d = ST_TERM_CR;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end
         end
`ifdef BCD_BANNER_TX_CRLF_EN
         ST_TERM_CR: begin
            if (!tx_full) begin
               wr      = 1'b1;
               char    = ASCII_CR;
               last_d  = ASCII_CR;
               state_d = ST_TERM_LF;
            end
         end
         ST_TERM_LF: begin
            if (!tx_full) begin
               wr      = 1'b1;
               char    = ASCII_LF;
               last_d  = ASCII_LF;
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   // The strobe is combinational on tx_full so a write lands in the first
   // free cycle; data_out shows the registered last character otherwise.
   assign wr_data   = wr;
   assign data_out  = char;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done_tick = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_banner_tx.sv
// Directed self-checking bench for bcd_banner_tx (DIGITS=6).
module tb_bcd_banner_tx;

   localparam int unsigned DIGITS = 6;
`ifdef BCD_BANNER_TX_CRLF_EN
   localparam int TAIL = 2;
`else
   localparam int TAIL = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        tx_full = 1'b0;
   logic [23:0] data_in = '0;
   logic [7:0]  data_out;
   logic        wr_data;
   logic        busy;
   logic        done_tick;

   int n_checks = 0;
   int n_err = 0;

   int cyc = 0;
   int t0 = 0;
   logic [7:0] got_q[$];
   int wr_lat_q[$];
   int done_cnt = 0;
   int done_lat = 0;
   int bad_strobe = 0;

   bcd_banner_tx #(
      .DIGITS   (DIGITS),
      .BAD_CHAR (8'h3F)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data_in   (data_in),
      .tx_full   (tx_full),
      .data_out  (data_out),
      .wr_data   (wr_data),
      .busy      (busy),
      .done_tick (done_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Latency 1 = the cycle right after the edge that sampled start
   always @(negedge clk) begin
      if (wr_data) begin
         got_q.push_back(data_out);
         wr_lat_q.push_back(cyc - t0 + 1);
      end
      if (done_tick) begin
         done_cnt++;
         done_lat = cyc - t0 + 1;
      end
      if (wr_data && tx_full) bad_strobe++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input logic [23:0] d);
      @(posedge clk);
      #1;
      got_q.delete();
      wr_lat_q.delete();
      done_cnt = 0;
      done_lat = 0;
      bad_strobe = 0;
      data_in = d;
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   // exp holds n characters, first character in the most significant byte
   task automatic check_frame(input string tag, input logic [63:0] exp_in, input int n_in,
                              input int exp_last_lat, input int exp_done_lat);
      logic [63:0] exp;
      int n;
      logic [7:0] b;
      exp = exp_in;
      n = n_in;
      if (TAIL != 0) begin
         exp = {exp[47:0], 16'h0D0A};
         n = n + 2;
      end
      check({tag, "_count"}, 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < got_q.size()) begin
            b = exp[8*(n-1-i) +: 8];
            check($sformatf("%s_ch%0d", tag, i), 32'(got_q[i]), 32'(b));
         end
      end
      if (wr_lat_q.size() == n) begin
         check({tag, "_first_lat"}, 32'(wr_lat_q[0]), 32'd1);
         check({tag, "_last_lat"}, 32'(wr_lat_q[n-1]), 32'(exp_last_lat));
      end
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_lat"}, 32'(done_lat), 32'(exp_done_lat));
      check({tag, "_strobe_full"}, 32'(bad_strobe), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done_tick), 32'h0);
      #1 reset = 1'b1;

      // Basic frame
      pulse_start(24'h123456);
      check("basic_busy", 32'(busy), 32'h1);
      wait_done(40);
      check_frame("basic", 64'h0000_3132_3334_3536, 6, 6 + TAIL, 7 + TAIL);
      check("hold_wr", 32'(wr_data), 32'h0);
      check("hold_data", 32'(data_out), (TAIL != 0) ? 32'h0A : 32'h36);

      // Zeros and sevens/nines
      pulse_start(24'h000709);
      wait_done(40);
      check_frame("mixed", 64'h0000_3030_3037_3039, 6, 6 + TAIL, 7 + TAIL);

      // Invalid nibbles
      pulse_start(24'hA00F00);
      wait_done(40);
      check_frame("bad", 64'h0000_3F30_303F_3030, 6, 6 + TAIL, 7 + TAIL);

      // Back-pressure for three cycles after two writes
      pulse_start(24'h654321);
      @(posedge clk); #1;
      @(posedge clk); #1;
      tx_full = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      tx_full = 1'b0;
      wait_done(40);
      check_frame("bp", 64'h0000_3635_3433_3231, 6, 9 + TAIL, 10 + TAIL);
      if (wr_lat_q.size() > 2) check("bp_resume_lat", 32'(wr_lat_q[2]), 32'd6);

      // Snapshot kept and start ignored while busy
      pulse_start(24'h314159);
      @(posedge clk); #1;
      @(posedge clk); #1;
      data_in = 24'h999999;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40);
      repeat (6) @(negedge clk);
      check_frame("snap", 64'h0000_3331_3431_3539, 6, 6 + TAIL, 7 + TAIL);

      // Start in the DONE cycle is ignored
      pulse_start(24'h000001);
      repeat (DIGITS + TAIL) begin
         @(posedge clk); #1;
      end
      check("donecyc_tick", 32'(done_tick), 32'h1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40);
      repeat (6) @(negedge clk);
      check_frame("donecyc", 64'h0000_3030_3030_3031, 6, 6 + TAIL, 7 + TAIL);

      // Reset mid-frame after two writes
      pulse_start(24'h777777);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("mid_rst_wr", 32'(wr_data), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_data", 32'(data_out), 32'h0);
      check("mid_rst_done", 32'(done_tick), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (12) @(negedge clk);
      check("mid_rst_writes", 32'(got_q.size()), 32'd2);
      check("mid_rst_done_cnt", 32'(done_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_banner_tx.md
Name: bcd_banner_tx

Overview:
Reverse path of the banner receiver. On request, snapshots the BCD digit set currently shown on the seven-segment displays and serialises it, most significant digit first, as ASCII characters into the UART transmit FIFO. The host can then read back the banner contents. It sits between the bcd_shift_register output (bcd_set) and the UART TX write port (data_in / wr_data / tx_full).

Parameters:
DIGITS, 6, number of BCD digits in the banner; the input bus is 4*DIGITS bits wide.
BAD_CHAR, 8'h3F, ASCII code sent for a nibble greater than 9 ('?').

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to transmit the banner.
data_in  input  4*DIGITS  BCD digit set; digit k occupies [4k+3:4k], and digit DIGITS-1 is the most significant.
tx_full  input  1  UART TX FIFO full; no write is issued while this is high.
data_out  output  8  ASCII character presented to the UART TX FIFO.
wr_data  output  1  one-cycle write strobe to the TX FIFO; data_out is valid whenever this is high.
busy  output  1  high from the cycle after an accepted start until done_tick.
done_tick  output  1  one-cycle pulse after the final character has been written.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; data_out=0, wr_data=0, busy=0, done_tick=0; snapshot register and digit index cleared. Reset asserted mid-frame aborts the frame, and nothing further is written.
- States: IDLE, SEND, TERM_CR, TERM_LF, DONE. The TERM_* states exist only with the optional feature.
- IDLE: when start=1, latch data_in into the snapshot, set index=DIGITS-1, go to SEND.
- Later changes on data_in do not affect a frame in progress.
- SEND: if tx_full=0, assert wr_data for one cycle with data_out = index digit + 8'h30.
  - If the digit is greater than 9, data_out = BAD_CHAR instead.
  - After the write, decrement index. After the write at index 0, go to TERM_CR (feature on) or DONE (feature off).
- SEND with tx_full=1: no write is issued; state and index are held. The write happens in the first cycle in which tx_full=0.
- Throughput: one character per cycle while tx_full=0.
- Latency: start is sampled at edge N; the first wr_data is high in cycle N+1 if tx_full=0.
- DONE: done_tick=1 for exactly one cycle, busy falls in the same cycle, then return to IDLE.
- Total frame length with no back-pressure, start edge to done_tick: DIGITS+1 cycles (feature off) or DIGITS+3 cycles (feature on).
- start while busy=1 is ignored; it is neither queued nor restarts the frame.
- start in the DONE cycle is also ignored. A new start is accepted only in IDLE.
- wr_data is never high while tx_full=1. data_out holds its last value when wr_data=0.
- Index arithmetic uses $clog2(DIGITS) bits; the index never wraps below 0.

Optional Feature:
Macro BCD_BANNER_TX_CRLF_EN.
- Defined: after the last digit, write 8'h0D (TERM_CR) and then 8'h0A (TERM_LF). Each write obeys the same tx_full rule.
- Undefined: the TERM states are not compiled in, and the frame is the DIGITS characters only.

Decomposition:
- Shared package/header: ASCII constants ('0'=8'h30, CR=8'h0D, LF=8'h0A, '?'=8'h3F) and the state encodings. These constants are reused by signal_decoder.
- One natural sub-module, bcd2ascii: combinational, 4-bit BCD in, 8-bit ASCII out, maps values above 9 to BAD_CHAR.
- The FSM, snapshot register and index counter stay in bcd_banner_tx.

Test Plan:
- Basic frame, feature off: data_in=24'h123456, start pulse, tx_full=0 → wr_data high for 6 consecutive cycles with 31,32,33,34,35,36; done_tick in the next cycle.
- Feature on: data_in=24'h000709 → writes 30,30,30,37,30,39,0D,0A; done_tick 9 cycles after the start edge.
- Back-pressure: tx_full=1 for 3 cycles in the middle of the frame → no writes during those cycles, the same character is written when tx_full falls, and there are no duplicates or skips.
- Invalid nibble: data_in=24'hA00F00 → first character 3F, fourth character 3F, the rest 30.
- Snapshot and start-while-busy: change data_in to 24'h999999 and pulse start in the middle of the frame → the original digits are still sent, and exactly one frame with one done_tick is produced.
- Reset mid-frame: assert reset after 2 writes → outputs are 0 immediately; after release, no writes occur until a new start.
